serial_tx: RTL and testbench

//   Serial-link transmitter; the send side of the SerialComm receiver (bit-sampling and bit-in-char counters).

---
 rtl/serial_tx.sv | 88 ++++++++
 tb/tb_serial_tx.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_tx.sv
// rtl/serial_tx.sv - 11-bit LSB-first serial frame transmitter (start, D0..D7, even parity, stop)
//
// Ports:
//   clk        system clock, all logic on posedge
//   reset      asynchronous active-low reset
//   load       send request, honoured only while ready=1
//   data_in    byte to send, sampled on the accepting edge
//   tx_out     serial line, idles high
//   ready      1 = idle, next load is accepted
//   busy       1 = frame in progress (always ~ready)
//   char_sent  one-cycle pulse after the stop bit completes

module serial_tx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] data_in,
  output logic       tx_out,
  output logic       ready,
  output logic       busy,
  output logic       char_sent
);

  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(CLKS_PER_BIT - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t        state;
  // Holds frame bits 1..10; the start bit goes straight to tx_out on accept,
  // so frame[0] is always the next bit to drive.
  logic [9:0]    frame;
  logic [3:0]    bit_cnt;
  logic [TW-1:0] tick_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      frame     <= '0;
      bit_cnt   <= '0;
      tick_cnt  <= '0;
      tx_out    <= 1'b1;
      ready     <= 1'b1;
      busy      <= 1'b0;
      char_sent <= 1'b0;
    end else begin
      char_sent <= 1'b0;
      case (state)
        IDLE: begin
          if (load) begin
            frame    <= {1'b1, ^data_in, data_in};
            bit_cnt  <= '0;
            tick_cnt <= '0;
            tx_out   <= 1'b0;
            ready    <= 1'b0;
            busy     <= 1'b1;
            state    <= SEND;
          end
        end
        SEND: begin
          if (tick_cnt == TICK_LAST) begin
            tick_cnt <= '0;
            if (bit_cnt == 4'd10) begin
              // Stop bit finished: line stays high, ready goes up in the
              // same cycle as char_sent so a back-to-back load is accepted.
              state     <= IDLE;
              bit_cnt   <= '0;
              tx_out    <= 1'b1;
              ready     <= 1'b1;
              busy      <= 1'b0;
              char_sent <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
              tx_out  <= frame[0];
              frame   <= {1'b1, frame[9:1]};
            end
          end else begin
            tick_cnt <= tick_cnt + TW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_tx.sv
// tb/tb_serial_tx.sv - scoreboard bench for serial_tx at CLKS_PER_BIT=4 and 16

module tb_serial_tx;

  localparam int C0 = 4;
  localparam int C1 = 16;

  typedef struct {
    logic [10:0] frame;
    int          acc;
    bit          b2b;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       load0 = 1'b0, load1 = 1'b0;
  logic [7:0] data0 = 8'h00, data1 = 8'h00;
  logic       tx0, rdy0, bsy0, cs0;
  logic       tx1, rdy1, bsy1, cs1;

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t q0[$];
  exp_t q1[$];
  bit   mon_act[2];
  int   end_cyc[2];

  serial_tx #(.CLKS_PER_BIT(C0)) dut0 (
    .clk(clk), .reset(reset), .load(load0), .data_in(data0),
    .tx_out(tx0), .ready(rdy0), .busy(bsy0), .char_sent(cs0)
  );

  serial_tx #(.CLKS_PER_BIT(C1)) dut1 (
    .clk(clk), .reset(reset), .load(load1), .data_in(data1),
    .tx_out(tx1), .ready(rdy1), .busy(bsy1), .char_sent(cs1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk1(string nm, logic a, logic e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %b required %b (cyc %0d)", nm, a, e, cyc);
    end
  endfunction

  function automatic void chkn(string nm, int a, int e);
    n_cmp++;
    if (a != e) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d (cyc %0d)", nm, a, e, cyc);
    end
  endfunction

  // Must be called at a negedge; returns at the following negedge.
  task automatic send(input int idx, input logic [7:0] d, input logic par,
                      input bit b2b, output int acc);
    exp_t e;
    acc     = cyc + 1;
    e.frame = {1'b1, par, d, 1'b0};
    e.acc   = acc;
    e.b2b   = b2b;
    if (idx == 0) begin load0 = 1'b1; data0 = d; q0.push_back(e); end
    else          begin load1 = 1'b1; data1 = d; q1.push_back(e); end
    @(negedge clk);
    if (idx == 0) load0 = 1'b0; else load1 = 1'b0;
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0 || mon_act[0] || mon_act[1]) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_done: frame still pending after %0d clks, required completion", budget);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic monitor(input int idx, input int c);
    exp_t e;
    bit   act = 1'b0;
    int   s = 0;
    int   bad = 0;
    logic tx, rdy, bsy, cs, b;
    string tag;
    tag = (idx == 0) ? "dut0" : "dut1";
    forever begin
      @(negedge clk);
      tx  = (idx == 0) ? tx0  : tx1;
      rdy = (idx == 0) ? rdy0 : rdy1;
      bsy = (idx == 0) ? bsy0 : bsy1;
      cs  = (idx == 0) ? cs0  : cs1;
      if (!reset) begin
        act = 1'b0;
        mon_act[idx] = 1'b0;
        continue;
      end
      if (!act) begin
        if (tx == 1'b0) begin
          if ((idx == 0 && q0.size() == 0) || (idx == 1 && q1.size() == 0)) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s unexpected_frame: got start bit at cyc %0d, required idle line", tag, cyc);
            continue;
          end
          e = (idx == 0) ? q0.pop_front() : q1.pop_front();
          act = 1'b1;
          mon_act[idx] = 1'b1;
          s = 0;
          bad = 0;
          chkn({tag, " start_cycle"}, cyc, e.acc);
          if (e.b2b) chkn({tag, " interframe_gap"}, cyc - end_cyc[idx], 1);
        end else begin
          n_cmp++;
          if (!(rdy === 1'b1 && bsy === 1'b0 && cs === 1'b0)) begin
            n_bad++;
            $display("FAIL %s idle: ready=%b busy=%b char_sent=%b required 1 0 0", tag, rdy, bsy, cs);
          end
        end
      end
      if (act) begin
        if (s < 11 * c) begin
          b = e.frame[s / c];
          if (tx !== b || rdy !== 1'b0 || bsy !== 1'b1 || cs !== 1'b0) bad++;
          if (s % c == c - 1) begin
            n_cmp++;
            if (bad != 0) begin
              n_bad++;
              $display("FAIL %s frame_bit%0d: tx=%b ready=%b busy=%b char_sent=%b (%0d bad samples), required tx=%b 0 1 0",
                       tag, s / c, tx, rdy, bsy, cs, bad, b);
            end
            bad = 0;
          end
        end else begin
          n_cmp++;
          if (!(cs === 1'b1 && tx === 1'b1 && rdy === 1'b1 && bsy === 1'b0)) begin
            n_bad++;
            $display("FAIL %s frame_end: char_sent=%b tx=%b ready=%b busy=%b required 1 1 1 0", tag, cs, tx, rdy, bsy);
          end
          end_cyc[idx] = cyc;
          act = 1'b0;
          mon_act[idx] = 1'b0;
        end
        s++;
      end
    end
  endtask

  initial monitor(0, C0);
  initial monitor(1, C1);

  initial begin
    int a, a2;
    int pulses[3];
    pulses = '{5, 20, 40};

    // Reset state
    @(negedge clk);
    chk1("reset tx_out", tx0, 1'b1);
    chk1("reset ready", rdy0, 1'b1);
    chk1("reset busy", bsy0, 1'b0);
    chk1("reset char_sent", cs0, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Idle with no load for 20 clks (monitor checks every cycle)
    repeat (20) @(negedge clk);

    // A5: 1,0,1,0,0,1,0,1 parity 0
    send(0, 8'hA5, 1'b0, 1'b0, a);
    wait_done(200);

    // 01 (parity 1) then FF (parity 0) loaded in the char_sent cycle
    send(0, 8'h01, 1'b1, 1'b0, a);
    wait_cyc(a + 11 * C0);
    chk1("b2b char_sent cycle ready", rdy0, 1'b1);
    send(0, 8'hFF, 1'b0, 1'b1, a2);
    wait_done(200);

    // Loads while busy are ignored; data_in changes do not alter the frame
    send(0, 8'h5A, 1'b0, 1'b0, a);
    for (int i = 0; i < 3; i++) begin
      wait_cyc(a + pulses[i]);
      load0 = 1'b1;
      data0 = 8'hC3 ^ 8'(i);
      @(negedge clk);
      load0 = 1'b0;
      data0 = 8'hFF;
    end
    wait_done(200);
    repeat (20) @(negedge clk);

    // Asynchronous reset during bit 4
    send(0, 8'h96, 1'b0, 1'b0, a);
    wait_cyc(a + 4 * C0 + 1);
    #2 reset = 1'b0;
    #1;
    chk1("async reset tx_out", tx0, 1'b1);
    chk1("async reset ready", rdy0, 1'b1);
    chk1("async reset busy", bsy0, 1'b0);
    chk1("async reset char_sent", cs0, 1'b0);
    repeat (3) @(negedge clk);
    chkn("aborted frame popped", q0.size(), 0);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    send(0, 8'h80, 1'b1, 1'b0, a);
    wait_done(200);

    // CLKS_PER_BIT=16
    send(1, 8'h3C, 1'b0, 1'b0, a);
    wait_done(400);

    chkn("queue0 empty at end", q0.size(), 0);
    chkn("queue1 empty at end", q1.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit, required completion");
    $fatal(1, "timeout");
  end

endmodule
